// File: rtl/asteroid_pool.sv
// Asteroid slot manager: periodic pseudo-random spawns into free slots, slope-driven
// movement with screen wrap-around, and slot clearing on delete requests.
module asteroid_pool #(
    parameter int          N_SLOTS      = 8,
    parameter int          X_W          = 10,
    parameter int          Y_W          = 10,
    parameter int          SCREEN_W     = 320,
    parameter int          SCREEN_H     = 240,
    parameter int          SPAWN_PERIOD = 60,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             tick,
    input  logic                             spawn_en,
    input  logic                             delete_valid,
    input  logic [4:0]                       delete_idx,
    output logic [N_SLOTS*(14+X_W+Y_W)-1:0]  entities,
    output logic [5:0]                       active_count,
    output logic                             full,
    output logic                             spawn_pending
);
    localparam int          E        = 14 + X_W + Y_W;
    localparam int          T_W      = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'hACE1 : SEED;

    typedef struct packed {
        logic           valid;
        logic [2:0]     sprite;
        logic [1:0]     y_q;
        logic [1:0]     x_q;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] x;
        logic [5:0]     slope;   // {y_neg, y_mag, x_neg, x_mag}
    } rec_t;

    rec_t           slot_q [N_SLOTS];
    rec_t           slot_d [N_SLOTS];
    rec_t           spawn_rec;
    logic [T_W-1:0] timer;
    logic           timer_wrap;
    logic [15:0]    lfsr;
    logic           pending;
    logic           spawn_found;
    logic [4:0]     spawn_idx;
    logic           spawn_go;
    logic [5:0]     count_d;
    logic [5:0]     count_q;
    logic           full_q;

    function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] v, input logic neg);
        if (neg) return (v == '0) ? X_W'(SCREEN_W - 1) : v - 1'b1;
        return (v == X_W'(SCREEN_W - 1)) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] v, input logic neg);
        if (neg) return (v == '0) ? Y_W'(SCREEN_H - 1) : v - 1'b1;
        return (v == Y_W'(SCREEN_H - 1)) ? '0 : v + 1'b1;
    endfunction

    assign timer_wrap = spawn_en && (timer == T_W'(SPAWN_PERIOD - 1));
    assign spawn_go   = pending && spawn_found;

    // Free-slot search and spawn record both come from pre-edge state only.
    always_comb begin
        spawn_found = 1'b0;
        spawn_idx   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!spawn_found && !slot_q[i].valid) begin
                spawn_found = 1'b1;
                spawn_idx   = 5'(i);
            end
        end

        spawn_rec        = '0;
        spawn_rec.valid  = 1'b1;
        spawn_rec.sprite = lfsr[9:7];
        spawn_rec.slope  = lfsr[6:1];
        if (lfsr[2:1] == 2'b00 && lfsr[5:4] == 2'b00)
            spawn_rec.slope[1:0] = 2'b01;
        if (lfsr[0])
            spawn_rec.x = X_W'(32'({1'b0, lfsr[15:1]}) % 32'(SCREEN_W));
        else
            spawn_rec.y = Y_W'(32'({1'b0, lfsr[15:1]}) % 32'(SCREEN_H));
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i].valid) begin
                if (delete_valid && delete_idx == 5'(i)) begin
                    slot_d[i] = '0;
                end else if (tick) begin
                    if (slot_q[i].x_q == 2'b00 && slot_q[i].y_q == 2'b00) begin
                        slot_d[i].x_q = slot_q[i].slope[1:0];
                        slot_d[i].y_q = slot_q[i].slope[4:3];
                    end else if (slot_q[i].x_q != 2'b00) begin
                        slot_d[i].x   = step_x(slot_q[i].x, slot_q[i].slope[2]);
                        slot_d[i].x_q = slot_q[i].x_q - 2'b01;
                    end else begin
                        slot_d[i].y   = step_y(slot_q[i].y, slot_q[i].slope[5]);
                        slot_d[i].y_q = slot_q[i].y_q - 2'b01;
                    end
                end
            end else if (spawn_go && spawn_idx == 5'(i)) begin
                slot_d[i] = spawn_rec;
            end else begin
                slot_d[i] = '0;
            end
            count_d = count_d + 6'(slot_d[i].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= '0;
            timer   <= '0;
            lfsr    <= SEED_EFF;
            pending <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) slot_q[i] <= slot_d[i];
            if (spawn_en) timer <= timer_wrap ? '0 : timer + 1'b1;
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            // A fresh request wins over clearing by a same-edge spawn.
            if (timer_wrap)    pending <= 1'b1;
            else if (spawn_go) pending <= 1'b0;
            count_q <= count_d;
            full_q  <= (count_d == 6'(N_SLOTS));
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
        assign entities[g*E +: E] = slot_q[g];
    end

    assign active_count  = count_q;
    assign full          = full_q;
    assign spawn_pending = pending;
endmodule
